// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: transforms COLS_PER_CYCLE columns per clock in a
// work register, with valid/ready handshakes on input and output.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         N         = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP  = 2'(N - 1);
  localparam logic [1:0] GRP_WIDTH = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q;
  logic [127:0] work_q;
  logic [127:0] work_calc;
  logic         ready_fsm;
  logic         accept;
  logic         last_grp;

  // GF(2^8) multiply by a 4-bit constant, built from the xtime chain b, 2b, 4b, 8b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_k(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
  endfunction

  // Byte a0 sits in the most significant position of the column word.
  function automatic logic [31:0] inv_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mul_k(a0, 4'd14) ^ mul_k(a1, 4'd11) ^ mul_k(a2, 4'd13) ^ mul_k(a3, 4'd9),
            mul_k(a0, 4'd9)  ^ mul_k(a1, 4'd14) ^ mul_k(a2, 4'd11) ^ mul_k(a3, 4'd13),
            mul_k(a0, 4'd13) ^ mul_k(a1, 4'd9)  ^ mul_k(a2, 4'd14) ^ mul_k(a3, 4'd11),
            mul_k(a0, 4'd11) ^ mul_k(a1, 4'd13) ^ mul_k(a2, 4'd9)  ^ mul_k(a3, 4'd14)};
  endfunction

  assign last_grp = (cnt_q == LAST_GRP);

  // Only the columns of the current group pass through the multipliers.
  always_comb begin
    logic [31:0] cols [4];
    logic [1:0]  col_idx;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    col_idx   = '0;
    work_calc = '0;
    for (int c = 0; c < 4; c++) cols[c] = work_q[127 - 32*c -: 32];
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx       = cnt_q * GRP_WIDTH + 2'(g);
      cols[col_idx] = inv_col(cols[col_idx]);
    end
    for (int c = 0; c < 4; c++) work_calc[127 - 32*c -: 32] = cols[c];
  end

  always_comb begin
    state_d   = state_q;
    ready_fsm = 1'b0;
    case (state_q)
      IDLE: begin
        ready_fsm = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last_grp) state_d = DONE;
      end
      DONE: begin
        ready_fsm = out_ready;
        if (out_ready) state_d = in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Held low during reset so upstream never sees a ready from a clearing block.
  assign in_ready = rst_n & ready_fsm;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // update together from pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      work_q    <= '0;
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state_q == CALC) begin
        work_q <= work_calc;
        cnt_q  <= last_grp ? 2'd0 : cnt_q + 2'd1;
        if (last_grp) begin
          state_out <= work_calc;
          out_valid <= 1'b1;
        end
      end
      if (state_q == DONE && out_ready) out_valid <= 1'b0;
      if (accept) begin
        work_q <= state_in;
        cnt_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4,
// against a bit-serial GF(2^8) reference model.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] state_in  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .state_in (state_in[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .state_out(state_out[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Shift-and-add multiply in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant column mix with first row c0..c3.
  function automatic logic [127:0] col_model(input logic [127:0] s, input logic [7:0] c0,
                                             input logic [7:0] c1, input logic [7:0] c2,
                                             input logic [7:0] c3);
    logic [7:0]   cf [4];
    logic [127:0] r;
    logic [7:0]   acc;
    cf[0] = c0; cf[1] = c1; cf[2] = c2; cf[3] = c3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(cf[(k - row) & 3], s[127 - 8*(4*c + k) -: 8]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_model(input logic [127:0] s);
    return col_model(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    return col_model(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_vec(input int idx, input logic [127:0] din, input string tag);
    int w;
    w = 0;
    state_in[idx] = din;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, 128'(in_ready[idx]), 128'(1));
    tick();
    in_valid[idx] = 1'b0;
    state_in[idx] = rand128();
  endtask

  task automatic wait_result(input int idx, input logic [127:0] exp, input string tag);
    int lat;
    lat = 0;
    while (!out_valid[idx] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(4 >> idx));
    check({tag, "_data"}, state_out[idx], exp);
  endtask

  task automatic consume(input int idx, input logic [127:0] exp, input string tag);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    check({tag, "_valid_drop"}, 128'(out_valid[idx]), 128'(0));
    check({tag, "_retained"}, state_out[idx], exp);
  endtask

  task automatic send(input int idx, input logic [127:0] din, input logic [127:0] exp,
                      input string tag);
    accept_vec(idx, din, tag);
    wait_result(idx, exp, tag);
    consume(idx, exp, tag);
  endtask

  task automatic run_backpressure();
    logic [127:0] a, b, ea, eb;
    a  = rand128();
    b  = rand128();
    ea = inv_mix_model(a);
    eb = inv_mix_model(b);
    accept_vec(0, a, "bp_first");
    wait_result(0, ea, "bp_first");
    in_valid[0] = 1'b1;
    state_in[0] = b;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_out%0d", i), state_out[0], ea);
      check($sformatf("bp_hold_ready%0d", i), 128'(in_ready[0]), 128'(0));
      check($sformatf("bp_hold_valid%0d", i), 128'(out_valid[0]), 128'(1));
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    state_in[0]  = rand128();
    wait_result(0, eb, "bp_second");
    consume(0, eb, "bp_second");
  endtask

  task automatic run_b2b();
    logic [127:0] vecs [8];
    logic [127:0] expq [$];
    int nin, nout, last_cyc;
    logic do_acc, do_con;
    nin = 0; nout = 0; last_cyc = 0;
    for (int i = 0; i < 8; i++) vecs[i] = rand128();
    state_in[0]  = vecs[0];
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
      do_acc = in_valid[0] && in_ready[0];
      do_con = out_valid[0] && out_ready[0];
      if (do_con) begin
        if (expq.size() == 0) check("b2b_spurious", 128'(out_valid[0]), 128'(0));
        else check($sformatf("b2b_out%0d", nout), state_out[0], expq.pop_front());
        if (nout > 0) check($sformatf("b2b_spacing%0d", nout), 128'(cyc - last_cyc), 128'(5));
        last_cyc = cyc;
        nout++;
      end
      if (do_acc) expq.push_back(inv_mix_model(vecs[nin]));
      tick();
      if (do_acc) begin
        nin++;
        if (nin < 8) state_in[0] = vecs[nin];
        else in_valid[0] = 1'b0;
      end
    end
    check("b2b_count", 128'(nout), 128'(8));
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
  endtask

  task automatic run_reset_midop();
    logic [127:0] a, b;
    a = rand128();
    b = rand128();
    accept_vec(0, a, "rst_abort");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
    check("rst_mid_state_out", state_out[0], 128'(0));
    check("rst_mid_in_ready", 128'(in_ready[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_mid_ready_after", 128'(in_ready[0]), 128'(1));
    send(0, b, inv_mix_model(b), "rst_fresh");
  endtask

  task automatic run_random(input int idx, input int n);
    logic [127:0] q [$];
    int nin, nout, cyc;
    logic do_acc, do_con;
    nin = 0; nout = 0; cyc = 0;
    while (nout < n && cyc < n * 40) begin
      in_valid[idx]  = (nin < n) && ($urandom_range(0, 3) != 0);
      state_in[idx]  = rand128();
      out_ready[idx] = ($urandom_range(0, 3) != 0);
      #1;
      do_acc = in_valid[idx] && in_ready[idx];
      do_con = out_valid[idx] && out_ready[idx];
      if (do_con) begin
        if (q.size() == 0) check("rand_spurious", 128'(out_valid[idx]), 128'(0));
        else check($sformatf("rand%0d_out%0d", idx, nout), state_out[idx], q.pop_front());
        nout++;
      end
      if (do_acc) begin
        q.push_back(inv_mix_model(state_in[idx]));
        nin++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check($sformatf("rand%0d_count", idx), 128'(nout), 128'(n));
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
  endtask

  initial begin
    vec_t tbl [4];
    logic [127:0] x;
    tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    tbl[1] = '{128'h80000000_4d7ebdf8_d5d5d7d6_00000000, 128'h41ecdaf7_2d26314c_d4d4d4d5_00000000};
    tbl[2] = '{128'h01000000_00010000_00000100_00000001, 128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e};
    tbl[3] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'hffffffff_ffffffff_ffffffff_ffffffff};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      state_in[i]  = '0;
    end
    #3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d_in_ready", i), 128'(in_ready[i]), 128'(0));
      check($sformatf("reset%0d_out_valid", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("reset%0d_state_out", i), state_out[i], 128'(0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("release%0d_in_ready", i), 128'(in_ready[i]), 128'(1));

    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 4; v++)
        send(i, tbl[v].din, tbl[v].dout, $sformatf("tbl_c%0d_v%0d", 1 << i, v));

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        x = rand128();
        send(i, mix_model(x), x, $sformatf("identity_c%0d_%0d", 1 << i, k));
      end

    run_backpressure();
    run_b2b();
    run_reset_midop();
    run_random(0, 1000);
    run_random(1, 200);
    run_random(2, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
